jcap_stream: RTL
================

JCAP_STREAM -- requirements
Module: jcap_stream

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64, meaning max WAIT-state cycles before abort (used only with JCAP_TIMEOUT_EN).
REQ-002 SHALL have parameter STB_MASK, default 6'b111111, meaning which mul_stb bits must arrive before capture.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a Jacobian capture.
REQ-006 SHALL have port j_in  input  384  twelve IEEE-754 single words, J0 at [31:0] ... J11 at [383:352].
REQ-007 SHALL have port mul_stb  input  6  per-multiplier result strobes from the Jacobian evaluator.
REQ-008 SHALL have port out_data  output  32  current streamed Jacobian word.
REQ-009 SHALL have port out_idx  output  4  index (0-11) of out_data.
REQ-010 SHALL have port out_valid  output  1  out_data/out_idx valid.
REQ-011 SHALL have port out_ready  input  1  downstream solver accepts the word.
REQ-012 SHALL have port out_last  output  1  high with out_valid when out_idx==11.
REQ-013 SHALL have port busy  output  1  high in WAIT or STREAM.
REQ-014 SHALL have port done  output  1  one-cycle pulse after word 11 handshake.
REQ-015 SHALL have port err  output  1  sticky timeout flag.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT, STREAM.
REQ-017 SHALL move IDLE->WAIT on start, clearing the 6-bit sticky strobe register in the same edge; start SHALL be ignored in WAIT/STREAM.
REQ-018 SHALL, in WAIT, OR (mul_stb & STB_MASK) into the sticky register each cycle.
REQ-019 SHALL, in the first WAIT cycle where (sticky | mul_stb) & STB_MASK == STB_MASK, latch all 384 bits of j_in into an internal 12x32 buffer and go to STREAM with idx=0 next cycle (strobes arriving together in one cycle count).
REQ-020 SHALL, in STREAM, drive out_valid=1, out_data=buffer[idx], out_idx=idx; j_in changes after capture SHALL NOT affect output.
REQ-021 SHALL hold out_data/out_idx stable while out_valid && !out_ready.
REQ-022 SHALL increment idx on each out_valid && out_ready; zero-bubble back-to-back transfers when out_ready stays high (12 words in 12 cycles).
REQ-023 SHALL, on handshake with idx==11, go to IDLE and pulse done for exactly the next cycle.
REQ-024 SHALL drive out_valid=0, out_last=0 outside STREAM; out_data/out_idx are don't-care but SHALL be 0 outside STREAM.
REQ-025 SHALL permit start in the done cycle (IDLE) to begin a new capture immediately.

Reset
REQ-026 SHALL, on rst high at a clock edge, enter IDLE and clear sticky, idx, buffer, timeout counter, out_valid, out_last, busy, done, err to 0, regardless of state.
REQ-027 SHALL give rst priority over start and over any in-progress handshake; a word presented in the reset cycle is not considered transferred.

Configuration
REQ-028 SHALL, with macro JCAP_TIMEOUT_EN defined, count WAIT cycles from 0; if the count reaches TIMEOUT_CYCLES without capture, return to IDLE, set err, and not pulse done.
REQ-029 SHALL, with JCAP_TIMEOUT_EN defined, clear err only on rst or the next accepted start.
REQ-030 SHALL, without JCAP_TIMEOUT_EN, wait indefinitely in WAIT, omit the counter, and tie err to 0.

Verification
REQ-031 SHALL cover: start, mul_stb=6'h3F one cycle later, j_in J0=32'h40400000, out_ready=1 -> 12 words on consecutive cycles, idx 0..11, last on idx 11, done pulse one cycle later.
REQ-032 SHALL cover: strobes arriving singly over 6 cycles, j_in changed after capture -> streamed words equal values present in capture cycle.
REQ-033 SHALL cover: out_ready toggled 1,0,0,1 pattern -> no word dropped or duplicated, data stable during stalls.
REQ-034 SHALL cover: rst asserted mid-STREAM at idx 5 -> next cycle out_valid=0, busy=0, idx=0; new start then streams from idx 0.
REQ-035 SHALL cover (JCAP_TIMEOUT_EN, TIMEOUT_CYCLES=8): start, mul_stb bit 5 never asserted -> err=1 after 8 WAIT cycles, state IDLE, done never pulses; next start clears err.
REQ-036 SHALL cover: start pulses during STREAM -> ignored, stream completes unchanged.

Source files
------------

// File: rtl/jcap_stream.sv
// Captures a 12-word Jacobian once the required multiplier strobes have arrived, then streams it out.
// Optional WAIT-state timeout with sticky err: define JCAP_TIMEOUT_EN.
module jcap_stream #(
  parameter int         TIMEOUT_CYCLES = 64,
  parameter logic [5:0] STB_MASK       = 6'b111111
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [383:0] j_in,
  input  logic [5:0]   mul_stb,
  output logic [31:0]  out_data,
  output logic [3:0]   out_idx,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_last,
  output logic         busy,
  output logic         done,
  output logic         err
);

  typedef enum logic [1:0] {IDLE, WAIT, STREAM} state_t;

  state_t      state, next_state;
  logic [5:0]  sticky;
  logic [3:0]  idx;
  logic [31:0] buffer [12];
  logic        done_r;
  logic        accept_start, capture, xfer;

`ifdef JCAP_TIMEOUT_EN
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TCW-1:0] tcnt;
  logic           timeout_hit;
  logic           err_r;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    next_state   = state;
    accept_start = 1'b0;
    capture      = 1'b0;
    xfer         = 1'b0;
`ifdef JCAP_TIMEOUT_EN
    timeout_hit  = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          accept_start = 1'b1;
          next_state   = WAIT;
        end
      end
      WAIT: begin
        // Strobes arriving in this very cycle count toward completion.
        if (((sticky | mul_stb) & STB_MASK) == STB_MASK) begin
          capture    = 1'b1;
          next_state = STREAM;
        end
`ifdef JCAP_TIMEOUT_EN
        else if (tcnt == TCW'(TIMEOUT_CYCLES - 1)) begin
          timeout_hit = 1'b1;
          next_state  = IDLE;
        end
`endif
      end
      STREAM: begin
        if (out_ready) begin
          xfer = 1'b1;
          if (idx == 4'd11) next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky <= '0;
      idx    <= '0;
      done_r <= 1'b0;
      // NOTE: the capture buffer is cleared on reset so stale Jacobian data never survives a reset.
      for (int i = 0; i < 12; i++) buffer[i] <= '0;
`ifdef JCAP_TIMEOUT_EN
      tcnt  <= '0;
      err_r <= 1'b0;
`endif
    end else begin
      done_r <= xfer && (idx == 4'd11);
      if (accept_start) begin
        sticky <= '0;
        idx    <= '0;
`ifdef JCAP_TIMEOUT_EN
        tcnt  <= '0;
        err_r <= 1'b0;
`endif
      end
      if (state == WAIT) begin
        sticky <= sticky | (mul_stb & STB_MASK);
`ifdef JCAP_TIMEOUT_EN
        tcnt <= tcnt + 1'b1;
`endif
      end
      if (capture) begin
        for (int i = 0; i < 12; i++) buffer[i] <= j_in[32*i +: 32];
        idx <= '0;
      end
      if (xfer) idx <= (idx == 4'd11) ? 4'd0 : idx + 4'd1;
`ifdef JCAP_TIMEOUT_EN
      if (timeout_hit) err_r <= 1'b1;
`endif
    end
  end

  assign out_valid = (state == STREAM);
  assign out_idx   = out_valid ? idx : 4'd0;
  assign out_data  = out_valid ? buffer[idx] : 32'd0;
  assign out_last  = out_valid && (idx == 4'd11);
  assign busy      = (state != IDLE);
  assign done      = done_r;
`ifdef JCAP_TIMEOUT_EN
  assign err       = err_r;
`else
  assign err       = 1'b0;
`endif

endmodule
